// File: rtl/bypass_select_ctrl.sv
// Bypass select controller: tracks producer tags through EX/MA and emits registered
// per-source-slot bypass selects that line up with the bypass network's data stages.
module bypass_select_ctrl #(
   parameter int INT_LANES = 2,
   parameter int MEM_LANES = 2,
   parameter int SRC_NUM   = 8,
   parameter int PREG_W    = 7,
   parameter int LANE_W    = 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          stall,
   input  logic                          clear,
   input  logic [INT_LANES-1:0]          int_dst_valid,
   input  logic [INT_LANES*PREG_W-1:0]   int_dst_preg,
   input  logic [MEM_LANES-1:0]          mem_dst_valid,
   input  logic [MEM_LANES*PREG_W-1:0]   mem_dst_preg,
   input  logic [SRC_NUM-1:0]            src_valid,
   input  logic [SRC_NUM*PREG_W-1:0]     src_preg,
   output logic [SRC_NUM-1:0]            sel_valid,
   output logic [SRC_NUM*2-1:0]          sel_stg,
   output logic [SRC_NUM*LANE_W-1:0]     sel_lane
);

   localparam logic [1:0] STG_INT_EX = 2'd0;
   localparam logic [1:0] STG_INT_WB = 2'd1;
   localparam logic [1:0] STG_MEM_MA = 2'd2;
   localparam logic [1:0] STG_MEM_WB = 2'd3;

   // WB-stage tags are never compared (their data comes from the register file
   // by then), so only the EX/MA tag stage is kept.
   logic [INT_LANES-1:0]        r_int_ex_vld;
   logic [INT_LANES*PREG_W-1:0] r_int_ex_preg;
   logic [MEM_LANES-1:0]        r_mem_ma_vld;
   logic [MEM_LANES*PREG_W-1:0] r_mem_ma_preg;

   logic [SRC_NUM-1:0]          r_sel_valid;
   logic [SRC_NUM*2-1:0]        r_sel_stg;
   logic [SRC_NUM*LANE_W-1:0]   r_sel_lane;

   logic [SRC_NUM-1:0]          w_sel_valid;
   logic [SRC_NUM*2-1:0]        w_sel_stg;
   logic [SRC_NUM*LANE_W-1:0]   w_sel_lane;

   for (genvar j = 0; j < SRC_NUM; j++) begin : g_slot
      logic              w_vld;
      logic [1:0]        w_stg;
      logic [LANE_W-1:0] w_lane;
      logic [PREG_W-1:0] w_src;

      assign w_src = src_preg[j*PREG_W +: PREG_W];

      // Scan from lowest to highest priority, descending lanes, so the last hit
      // written is the newest producer on the lowest lane.
      always_comb begin
         w_vld  = 1'b0;
         w_stg  = STG_INT_EX;
         w_lane = '0;
         if (src_valid[j]) begin
            for (int i = MEM_LANES-1; i >= 0; i--) begin
               if (r_mem_ma_vld[i] && r_mem_ma_preg[i*PREG_W +: PREG_W] == w_src) begin
                  w_vld  = 1'b1;
                  w_stg  = STG_MEM_WB;
                  w_lane = LANE_W'(i);
               end
            end
            for (int i = INT_LANES-1; i >= 0; i--) begin
               if (r_int_ex_vld[i] && r_int_ex_preg[i*PREG_W +: PREG_W] == w_src) begin
                  w_vld  = 1'b1;
                  w_stg  = STG_INT_WB;
                  w_lane = LANE_W'(i);
               end
            end
            for (int i = MEM_LANES-1; i >= 0; i--) begin
               if (mem_dst_valid[i] && mem_dst_preg[i*PREG_W +: PREG_W] == w_src) begin
                  w_vld  = 1'b1;
                  w_stg  = STG_MEM_MA;
                  w_lane = LANE_W'(i);
               end
            end
            for (int i = INT_LANES-1; i >= 0; i--) begin
               if (int_dst_valid[i] && int_dst_preg[i*PREG_W +: PREG_W] == w_src) begin
                  w_vld  = 1'b1;
                  w_stg  = STG_INT_EX;
                  w_lane = LANE_W'(i);
               end
            end
         end
      end

      assign w_sel_valid[j]                   = w_vld;
      assign w_sel_stg[j*2 +: 2]              = w_stg;
      assign w_sel_lane[j*LANE_W +: LANE_W]   = w_lane;
   end

   // Stall freezes tags and selects in lock-step with the network data stages.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         r_int_ex_vld <= '0;
         r_mem_ma_vld <= '0;
         r_sel_valid  <= '0;
         r_sel_stg    <= '0;
         r_sel_lane   <= '0;
      end else if (!stall) begin
         r_int_ex_vld  <= int_dst_valid;
         r_int_ex_preg <= int_dst_preg;
         r_mem_ma_vld  <= mem_dst_valid;
         r_mem_ma_preg <= mem_dst_preg;
         r_sel_valid   <= w_sel_valid;
         r_sel_stg     <= w_sel_stg;
         r_sel_lane    <= w_sel_lane;
      end
   end

   assign sel_valid = r_sel_valid;
   assign sel_stg   = r_sel_stg;
   assign sel_lane  = r_sel_lane;

endmodule

// File: tb/tb_bypass_select_ctrl.sv
// Directed scoreboard bench for bypass_select_ctrl: each step pushes the select
// expected one cycle later and pops it after the clock edge.
module tb_bypass_select_ctrl;

   localparam int IL = 2, ML = 2, SN = 8, PW = 7, LW = 1;

   logic               clk = 1'b0;
   logic               rst, stall, clear;
   logic [IL-1:0]      int_dst_valid;
   logic [IL*PW-1:0]   int_dst_preg;
   logic [ML-1:0]      mem_dst_valid;
   logic [ML*PW-1:0]   mem_dst_preg;
   logic [SN-1:0]      src_valid;
   logic [SN*PW-1:0]   src_preg;
   logic [SN-1:0]      sel_valid;
   logic [SN*2-1:0]    sel_stg;
   logic [SN*LW-1:0]   sel_lane;

   bypass_select_ctrl #(.INT_LANES(IL), .MEM_LANES(ML), .SRC_NUM(SN), .PREG_W(PW), .LANE_W(LW)) dut (
      .clk(clk), .rst(rst), .stall(stall), .clear(clear),
      .int_dst_valid(int_dst_valid), .int_dst_preg(int_dst_preg),
      .mem_dst_valid(mem_dst_valid), .mem_dst_preg(mem_dst_preg),
      .src_valid(src_valid), .src_preg(src_preg),
      .sel_valid(sel_valid), .sel_stg(sel_stg), .sel_lane(sel_lane)
   );

   always #5 clk = ~clk;

   typedef struct {
      string        tag;
      logic [SN-1:0]    v;
      logic [SN*2-1:0]  s;
      logic [SN*LW-1:0] l;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_err = 0;

   logic [SN-1:0]    ev;
   logic [SN*2-1:0]  es;
   logic [SN*LW-1:0] el;

   task automatic clr_in();
      stall = 0; clear = 0;
      int_dst_valid = '0; int_dst_preg = '0;
      mem_dst_valid = '0; mem_dst_preg = '0;
      src_valid = '0; src_preg = '0;
      ev = '0; es = '0; el = '0;
   endtask

   task automatic drv_int(input int l, input logic [PW-1:0] p);
      int_dst_valid[l] = 1'b1; int_dst_preg[l*PW +: PW] = p;
   endtask

   task automatic drv_mem(input int l, input logic [PW-1:0] p);
      mem_dst_valid[l] = 1'b1; mem_dst_preg[l*PW +: PW] = p;
   endtask

   task automatic drv_src(input int j, input logic v, input logic [PW-1:0] p);
      src_valid[j] = v; src_preg[j*PW +: PW] = p;
   endtask

   task automatic e_set(input int j, input logic [1:0] stg, input logic [LW-1:0] lane);
      ev[j] = 1'b1; es[j*2 +: 2] = stg; el[j*LW +: LW] = lane;
   endtask

   // Push the expectation for the drive just applied, clock once, then pop and compare.
   task automatic step(input string tag);
      exp_t e;
      sb.push_back('{tag, ev, es, el});
      @(posedge clk);
      #1;
      n_cmp++;
      if (sb.size() == 0) begin
         n_err++;
         $display("FAIL %s: scoreboard empty", tag);
      end else begin
         e = sb.pop_front();
         assert (sel_valid === e.v && sel_stg === e.s && sel_lane === e.l)
         else begin
            n_err++;
            $error("FAIL %s: got v=%h stg=%h lane=%h, want v=%h stg=%h lane=%h",
                   e.tag, sel_valid, sel_stg, sel_lane, e.v, e.s, e.l);
         end
      end
      clr_in();
   endtask

   initial begin
      clr_in();
      rst = 1'b1;
      // Reset dominates a same-cycle match and a stall
      drv_int(0, 7'h12); drv_src(0, 1, 7'h12); stall = 1;
      step("reset_hold");
      step("reset_idle");
      rst = 1'b0;

      // Same-cycle int RR forwarding, lane index
      drv_int(0, 7'h13); drv_int(1, 7'h12);
      drv_src(0, 1, 7'h12); drv_src(1, 1, 7'h13);
      e_set(0, 2'd0, 1'b1); e_set(1, 2'd0, 1'b0);
      step("int_rr_lane");

      // INT_WB one cycle later, then no bypass once past WB
      drv_int(0, 7'h05);
      step("int_prod_only");
      drv_src(3, 1, 7'h05); e_set(3, 2'd1, 1'b0);
      step("int_wb_hit");
      drv_src(3, 1, 7'h05);
      step("past_wb_miss");

      // Newest wins: int RR over MEM_WB
      drv_mem(1, 7'h20);
      step("mem_prod_only");
      drv_int(0, 7'h20); drv_src(2, 1, 7'h20); e_set(2, 2'd0, 1'b0);
      step("int_rr_over_mem_wb");
      // mem RR over int_ex; invalid source never bypasses
      drv_mem(1, 7'h20); drv_src(2, 1, 7'h20); drv_src(0, 0, 7'h20);
      e_set(2, 2'd2, 1'b1);
      step("mem_rr_over_int_wb");
      drv_src(2, 1, 7'h20); drv_src(0, 0, 7'h20); e_set(2, 2'd3, 1'b1);
      step("mem_wb_hit_src_invalid");

      // Stall freezes tags and selects; new producers during stall ignored
      drv_mem(0, 7'h33); drv_src(1, 1, 7'h33); e_set(1, 2'd2, 1'b0);
      step("mem_rr_hit");
      for (int k = 0; k < 3; k++) begin
         stall = 1; drv_int(1, 7'h33); drv_src(5, 1, 7'h33);
         e_set(1, 2'd2, 1'b0);
         step($sformatf("stall_hold_%0d", k));
      end
      drv_src(5, 1, 7'h33); e_set(5, 2'd3, 1'b0);
      step("stall_release_mem_wb");

      // Clear wins over stall, and drops the in-flight tags
      drv_int(0, 7'h40); drv_mem(1, 7'h41); drv_src(0, 1, 7'h40);
      e_set(0, 2'd0, 1'b0);
      step("pre_clear_hit");
      stall = 1; clear = 1; drv_int(1, 7'h40);
      drv_src(0, 1, 7'h40); drv_src(1, 1, 7'h41);
      step("clear_in_stall");
      drv_src(0, 1, 7'h40); drv_src(1, 1, 7'h41);
      step("post_clear_miss");

      // int_ex over mem_ma; mem RR over int_ex; int RR ascending lane
      drv_int(1, 7'h50); drv_mem(0, 7'h50);
      step("prod_50");
      drv_mem(1, 7'h50); drv_int(0, 7'h60); drv_int(1, 7'h60);
      drv_src(6, 1, 7'h50); drv_src(4, 1, 7'h60);
      e_set(6, 2'd2, 1'b1); e_set(4, 2'd0, 1'b0);
      step("mixed_prio");
      drv_src(7, 1, 7'h60); drv_src(6, 1, 7'h50);
      e_set(7, 2'd1, 1'b0); e_set(6, 2'd3, 1'b1);
      step("wb_lane_prio");

      // Mid-operation reset with stall
      drv_int(0, 7'h70); drv_src(2, 1, 7'h70); e_set(2, 2'd0, 1'b0);
      step("pre_rst_hit");
      rst = 1; stall = 1; drv_src(2, 1, 7'h70);
      step("rst_in_stall");
      rst = 0; drv_src(2, 1, 7'h70);
      step("post_rst_miss");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
